menu_nav_fsm: RTL and testbench

//  Parametrised top-level menu controller: N selectable items, last item = EXIT.

---
 rtl/menu_nav_fsm.sv | 183 ++++++++++++++++++
 tb/tb_menu_nav_fsm.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/menu_nav_fsm.sv
// menu_nav_fsm: top-level menu controller.
//
// Walks a highlight over N_ITEMS entries (the last one is EXIT) from debounced
// button levels, with wrap-around and hold-to-repeat on up/down. Confirming a
// game item emits a one-cycle game_start and hands the screen to the game until
// game_done; confirming EXIT parks the controller in a terminal halt state.
//
// Ports:
//   sys_clk       system clock
//   sys_rst_n     synchronous reset, active-high despite the name
//   btn_up        debounced level, move highlight up (towards 0, wraps)
//   btn_down      debounced level, move highlight down (towards N_ITEMS-1, wraps)
//   btn_left      debounced level, abort the running game
//   btn_right     debounced level, confirm/enter
//   game_done     one-cycle pulse from the running game
//   sel_idx       highlighted menu item
//   game_start    one-cycle pulse: launch game sel_idx
//   game_abort    one-cycle pulse: ask the running game to stop
//   in_game       high while a game owns the screen
//   halted        high once EXIT has been confirmed
//   state_output  encoded state: 0 menu, 1 launch, 2 run, 3 halt
//
// Every output is a flop or a decode of flops; no input reaches an output
// combinationally.
module menu_nav_fsm #(
    parameter int unsigned N_ITEMS     = 3,
    parameter int unsigned IDX_W       = 4,
    parameter int unsigned REPEAT_DLY  = 50_000_000,
    parameter int unsigned REPEAT_RATE = 10_000_000,
    parameter bit          RETURN_HOME = 1'b0
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             btn_left,
    input  logic             btn_right,
    input  logic             game_done,
    output logic [IDX_W-1:0] sel_idx,
    output logic             game_start,
    output logic             game_abort,
    output logic             in_game,
    output logic             halted,
    output logic [1:0]       state_output
);

    typedef enum logic [1:0] {
        StMenu   = 2'd0,
        StLaunch = 2'd1,
        StRun    = 2'd2,
        StHalt   = 2'd3
    } state_e;

    localparam int unsigned CntMax = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    localparam logic [IDX_W-1:0] LastIdx  = IDX_W'(N_ITEMS - 1);
    localparam logic [CntW-1:0]  DlyEnd   = CntW'(REPEAT_DLY - 1);
    localparam logic [CntW-1:0]  RateEnd  = CntW'(REPEAT_RATE - 1);
    localparam bit               RepeatEn = (REPEAT_RATE != 0);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] sel_q, sel_d;
    logic [3:0]       btn_prev_q;
    logic             abort_q, abort_d;
    logic             pend_q, pend_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    // 0: waiting for the initial hold delay, 1: stepping at the repeat rate
    logic             phase_q, phase_d;

    logic [3:0] btn_lvl;
    logic [3:0] press;
    logic       press_up, press_dn, press_left, press_right;
    logic       one_held;
    logic       auto_step, step_dn, step_up;

    // Bit order {right, left, down, up}
    assign btn_lvl     = {btn_right, btn_left, btn_down, btn_up};
    assign press       = btn_lvl & ~btn_prev_q;
    assign press_up    = press[0];
    assign press_dn    = press[1];
    assign press_left  = press[2];
    assign press_right = press[3];
    assign one_held    = btn_up ^ btn_down;

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        abort_d   = 1'b0;
        pend_d    = pend_q;
        cnt_d     = '0;
        phase_d   = 1'b0;
        auto_step = 1'b0;
        step_dn   = 1'b0;
        step_up   = 1'b0;

        unique case (state_q)
            StMenu: begin
                // The counter counts held cycles including the press cycle, so
                // a fresh press restarts it at 1. Any other cycle leaves it at 0.
                if (RepeatEn && one_held) begin
                    if (press_up || press_dn) begin
                        cnt_d = CntW'(1);
                    end else if (!phase_q) begin
                        if (cnt_q == DlyEnd) begin
                            auto_step = 1'b1;
                            phase_d   = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CntW'(1);
                        end
                    end else begin
                        phase_d = 1'b1;
                        if (cnt_q == RateEnd) begin
                            auto_step = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CntW'(1);
                        end
                    end
                end

                step_dn = press_dn | (auto_step & btn_down);
                step_up = press_up | (auto_step & btn_up);

                if (step_dn) begin
                    sel_d = (sel_q == LastIdx) ? '0 : sel_q + IDX_W'(1);
                end else if (step_up) begin
                    sel_d = (sel_q == '0) ? LastIdx : sel_q - IDX_W'(1);
                end else if (press_right) begin
                    state_d = (sel_q == LastIdx) ? StHalt : StLaunch;
                    cnt_d   = '0;
                    phase_d = 1'b0;
                end
            end
            StLaunch: begin
                state_d = StRun;
            end
            StRun: begin
                // game_done wins over a same-cycle abort request
                if (game_done) begin
                    state_d = StMenu;
                    pend_d  = 1'b0;
                    if (RETURN_HOME) begin
                        sel_d = '0;
                    end
                end else if (press_left && !pend_q) begin
                    abort_d = 1'b1;
                    pend_d  = 1'b1;
                end
            end
            StHalt: begin
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst_n) begin
            state_q    <= StMenu;
            sel_q      <= '0;
            // Levels held through reset must not look like presses afterwards
            btn_prev_q <= btn_lvl;
            abort_q    <= 1'b0;
            pend_q     <= 1'b0;
            cnt_q      <= '0;
            phase_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            btn_prev_q <= btn_lvl;
            abort_q    <= abort_d;
            pend_q     <= pend_d;
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
        end
    end

    assign sel_idx      = sel_q;
    assign game_start   = (state_q == StLaunch);
    assign game_abort   = abort_q;
    assign in_game      = (state_q == StLaunch) || (state_q == StRun);
    assign halted       = (state_q == StHalt);
    assign state_output = state_q;

endmodule

// File: tb/tb_menu_nav_fsm.sv
// Bench for menu_nav_fsm: directed scenarios followed by random button traffic,
// every cycle compared against a behavioural model of the menu rules.
module tb_menu_nav_fsm;

    localparam int N    = 3;
    localparam int DLY  = 8;
    localparam int RATE = 4;
    localparam bit RH   = 1'b0;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b1;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic       game_done = 1'b0;
    logic [3:0] sel_idx;
    logic       game_start, game_abort, in_game, halted;
    logic [1:0] state_output;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: mode 0 menu, 1 launch, 2 run, 3 halt; m_held counts consecutive
    // menu cycles with exactly one of up/down held (press cycle = 1).
    int       m_mode = 0, m_sel = 0, m_held = 0;
    bit       m_pend = 1'b0, m_abort = 1'b0;
    bit [3:0] m_prev = 4'b0;

    always #5 sys_clk = ~sys_clk;

    menu_nav_fsm #(
        .N_ITEMS    (N),
        .IDX_W      (4),
        .REPEAT_DLY (DLY),
        .REPEAT_RATE(RATE),
        .RETURN_HOME(RH)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .btn_up      (btn_up),
        .btn_down    (btn_down),
        .btn_left    (btn_left),
        .btn_right   (btn_right),
        .game_done   (game_done),
        .sel_idx     (sel_idx),
        .game_start  (game_start),
        .game_abort  (game_abort),
        .in_game     (in_game),
        .halted      (halted),
        .state_output(state_output)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input bit rst, input bit u, input bit d, input bit l,
                              input bit r, input bit done);
        bit [3:0] lv;
        bit [3:0] pr;
        bit       auto_s, act_dn, act_up;
        lv = {r, l, d, u};
        if (rst) begin
            m_mode = 0; m_sel = 0; m_held = 0; m_pend = 0; m_abort = 0; m_prev = lv;
            return;
        end
        pr      = lv & ~m_prev;
        m_prev  = lv;
        m_abort = 1'b0;
        auto_s  = 1'b0;
        case (m_mode)
            0: begin
                if ((u != d) && RATE != 0) begin
                    if (pr[0] || pr[1]) begin
                        m_held = 1;
                    end else begin
                        m_held++;
                        auto_s = (m_held == DLY) ||
                                 (m_held > DLY && ((m_held - DLY) % RATE) == 0);
                    end
                end else begin
                    m_held = 0;
                end
                act_dn = pr[1] || (auto_s && d);
                act_up = pr[0] || (auto_s && u);
                if (act_dn) m_sel = (m_sel + 1) % N;
                else if (act_up) m_sel = (m_sel + N - 1) % N;
                else if (pr[3]) begin
                    m_mode = (m_sel == N - 1) ? 3 : 1;
                    m_held = 0;
                end
            end
            1: begin m_mode = 2; m_held = 0; end
            2: begin
                m_held = 0;
                if (done) begin
                    m_mode = 0;
                    m_pend = 0;
                    if (RH) m_sel = 0;
                end else if (pr[2] && !m_pend) begin
                    m_abort = 1'b1;
                    m_pend  = 1'b1;
                end
            end
            default: m_held = 0;
        endcase
    endtask

    // One clock: drive inputs, advance the model on the edge, compare 1 ns later.
    task automatic step(input bit rst, input bit u, input bit d, input bit l,
                        input bit r, input bit done);
        sys_rst_n = rst;
        btn_up    = u;
        btn_down  = d;
        btn_left  = l;
        btn_right = r;
        game_done = done;
        @(posedge sys_clk);
        model_edge(rst, u, d, l, r, done);
        #1;
        check_eq("state", int'(state_output), m_mode);
        check_eq("sel", int'(sel_idx), m_sel);
        check_eq("start", int'(game_start), int'(m_mode == 1));
        check_eq("abort", int'(game_abort), int'(m_abort));
        check_eq("in_game", int'(in_game), int'(m_mode == 1 || m_mode == 2));
        check_eq("halted", int'(halted), int'(m_mode == 3));
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        bit u, d, l, r;

        // Reset values
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        check_eq("rst_sel", int'(sel_idx), 0);
        check_eq("rst_state", int'(state_output), 0);
        idle();

        // Wrap both ways
        step(0, 0, 1, 0, 0, 0); check_eq("dn1", int'(sel_idx), 1); idle();
        step(0, 0, 1, 0, 0, 0); check_eq("dn2", int'(sel_idx), 2); idle();
        step(0, 0, 1, 0, 0, 0); check_eq("dn_wrap", int'(sel_idx), 0); idle();
        step(0, 1, 0, 0, 0, 0); check_eq("up_wrap", int'(sel_idx), 2); idle();
        step(0, 0, 1, 0, 0, 0); idle();

        // Simultaneous presses: down wins
        step(0, 1, 1, 0, 0, 0); check_eq("updn", int'(sel_idx), 1); idle();
        step(0, 0, 1, 0, 1, 0); check_eq("rdn_sel", int'(sel_idx), 2);
        check_eq("rdn_state", int'(state_output), 0); idle();
        step(0, 1, 0, 0, 0, 0); idle();
        step(0, 1, 0, 0, 0, 0); idle();

        // Hold-to-repeat from item 0
        for (int i = 1; i <= 20; i++) begin
            step(0, 0, 1, 0, 0, 0);
            if (i == 7) check_eq("rpt_c7", int'(sel_idx), 1);
            if (i == 8) check_eq("rpt_c8", int'(sel_idx), 2);
        end
        check_eq("rpt_c20", int'(sel_idx), 2);
        idle();
        check_eq("rpt_rel", int'(sel_idx), 2);
        step(0, 1, 0, 0, 0, 0); idle();

        // Launch item 1, menu buttons ignored, game_done returns
        step(0, 0, 0, 0, 1, 0);
        check_eq("launch_start", int'(game_start), 1);
        check_eq("launch_state", int'(state_output), 1);
        idle();
        check_eq("run_state", int'(state_output), 2);
        check_eq("run_start", int'(game_start), 0);
        step(0, 0, 1, 0, 0, 0); check_eq("run_dn", int'(sel_idx), 1); idle();
        step(0, 0, 0, 0, 0, 1);
        check_eq("done_state", int'(state_output), 0);
        check_eq("done_sel", int'(sel_idx), 1);
        check_eq("done_ingame", int'(in_game), 0);

        // Abort: one pulse for two presses
        step(0, 0, 0, 0, 1, 0); idle();
        step(0, 0, 0, 1, 0, 0); check_eq("abort1", int'(game_abort), 1); idle();
        check_eq("abort_end", int'(game_abort), 0);
        step(0, 0, 0, 1, 0, 0); check_eq("abort2", int'(game_abort), 0); idle();
        step(0, 0, 0, 0, 0, 1);
        // Done beats a same-cycle abort
        step(0, 0, 0, 0, 1, 0); idle();
        step(0, 0, 0, 1, 0, 1);
        check_eq("ld_abort", int'(game_abort), 0);
        check_eq("ld_state", int'(state_output), 0);
        idle();

        // EXIT -> halt, inputs ignored, reset recovers
        step(0, 0, 1, 0, 0, 0); idle();
        step(0, 0, 0, 0, 1, 0);
        check_eq("halt", int'(halted), 1);
        idle();
        step(0, 1, 1, 1, 1, 1); idle();
        check_eq("halt_hold", int'(state_output), 3);
        step(1, 0, 0, 0, 0, 0); idle();
        check_eq("halt_rst", int'(sel_idx), 0);

        // Reset mid-run with right held: no launch afterwards
        step(0, 0, 0, 0, 1, 0); idle();
        step(1, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        check_eq("rst_run_start", int'(game_start), 0);
        step(0, 0, 0, 0, 1, 0);
        check_eq("rst_run_state", int'(state_output), 0);
        idle();

        // Random traffic with held levels so repeat fires
        u = 0; d = 0; l = 0; r = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(7) == 0)  u = ~u;
            if ($urandom_range(7) == 0)  d = ~d;
            if ($urandom_range(7) == 0)  l = ~l;
            if ($urandom_range(15) == 0) r = ~r;
            step(($urandom_range(299) == 0), u, d, l, r, ($urandom_range(15) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
